m6502_timer_slave: RTL

Memory-mapped bus responder on the M6502 CPU bus. It consumes the CPU's address, write data and write-enable, and returns read data, `rdy` and `irq_n`. It contains a 16-bit programmable down-counter timer with prescaler, auto-reload/one-shot modes, a maskable interrupt, and optional read wait-state insertion. It sits between the CPU wrapper and the system interconnect, in a 16-byte window at BASE_ADDR.

---
 rtl/m6502_timer_pkg.sv | 34 +++
 rtl/m6502_timer_slave_if.sv | 13 +
 rtl/m6502_timer_core.sv | 42 ++++
 rtl/m6502_timer_slave.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/m6502_timer_pkg.sv
// m6502_timer_pkg: register map, bit indices and reset constants for the M6502 timer slave
package m6502_timer_pkg;

    localparam logic [3:0] REG_CTRL      = 4'h0;
    localparam logic [3:0] REG_STATUS    = 4'h1;
    localparam logic [3:0] REG_RELOAD_LO = 4'h2;
    localparam logic [3:0] REG_RELOAD_HI = 4'h3;
    localparam logic [3:0] REG_COUNT_LO  = 4'h4;
    localparam logic [3:0] REG_COUNT_HI  = 4'h5;
    localparam logic [3:0] REG_SCRATCH0  = 4'h6;
    localparam logic [3:0] REG_SCRATCH1  = 4'h7;

    localparam int CTRL_EN          = 0;
    localparam int CTRL_IRQ_EN      = 1;
    localparam int CTRL_AUTO_RELOAD = 2;
    localparam int STATUS_UF        = 0;
    localparam int STATUS_RUN       = 1;

    localparam logic [7:0]  RST_BYTE  = 8'h00;
    localparam logic [15:0] RST_COUNT = 16'h0000;

    typedef enum logic {S_IDLE, S_WAIT} rd_state_e;

    typedef struct packed {
        logic auto_reload;
        logic irq_en;
        logic en;
    } ctrl_t;

    function automatic logic in_window(input logic [15:0] addr, input logic [15:0] base);
        return addr[15:4] == base[15:4];
    endfunction

endpackage

// File: rtl/m6502_timer_slave_if.sv
// m6502_timer_slave_if: CPU-side bus of the timer slave (address, data, strobes, ready, irq)
interface m6502_timer_slave_if;
    logic [15:0] addr;
    logic [7:0]  bus_wdata;
    logic        we_n;
    logic [7:0]  bus_rdata;
    logic        rdy;
    logic        irq_n;
    logic        hit;

    modport master (output addr, bus_wdata, we_n, input bus_rdata, rdy, irq_n, hit);
    modport slave  (input addr, bus_wdata, we_n, output bus_rdata, rdy, irq_n, hit);
endinterface

// File: rtl/m6502_timer_core.sv
// m6502_timer_core: prescaler plus 16-bit down-counter with reload/one-shot underflow handling
module m6502_timer_core #(
    parameter int PRESCALE = 8
) (
    input  logic        clk,
    input  logic        res_n,
    input  logic        en,
    input  logic        auto_reload,
    input  logic        load,
    input  logic [15:0] load_val,
    input  logic [15:0] reload,
    output logic [15:0] count,
    output logic        uf_pulse,
    output logic        en_clear
);
    import m6502_timer_pkg::*;

    localparam logic [7:0] PRE_MAX = 8'(PRESCALE - 1);

    logic [7:0] pre;
    logic       tick;

    assign tick     = en && pre == PRE_MAX;
    // a load in the same cycle swallows the tick entirely
    assign uf_pulse = tick && !load && count == RST_COUNT;
    assign en_clear = uf_pulse && !auto_reload;

    always_ff @(posedge clk) begin
        if (!res_n) begin
            pre   <= 8'h00;
            count <= RST_COUNT;
        end else if (load) begin
            pre   <= 8'h00;
            count <= load_val;
        end else if (en) begin
            pre <= tick ? 8'h00 : pre + 8'h01;
            if (tick)
                count <= count != RST_COUNT ? count - 16'h0001 : auto_reload ? reload : count;
        end
    end

endmodule

// File: rtl/m6502_timer_slave.sv
// m6502_timer_slave: M6502 bus timer slave; define M6502_TIMER_WAIT_EN for read wait states
module m6502_timer_slave
    import m6502_timer_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR   = 16'hD000,
    parameter int          PRESCALE    = 8,
    parameter int          WAIT_CYCLES = 2
) (
    input logic                  clk,
    input logic                  res_n,
    m6502_timer_slave_if.slave   bus
);

    ctrl_t       ctrl;
    logic        uf;
    logic [7:0]  reload_lo, reload_hi, scratch0, scratch1, shadow;
    logic [7:0]  rdata_q, mux_data;
    logic        irq_q;
    logic [3:0]  off, mux_off;
    logic        acc, wr, rd, load, capture;
    logic        uf_pulse, en_clear;
    logic [15:0] count;

    assign bus.hit       = in_window(bus.addr, BASE_ADDR);
    assign bus.bus_rdata = rdata_q;
    assign bus.irq_n     = irq_q;
    assign off           = bus.addr[3:0];
    assign acc           = bus.hit && bus.rdy;
    assign wr            = acc && !bus.we_n;
    assign rd            = acc && bus.we_n;
    assign load          = wr && off == REG_RELOAD_HI;

    m6502_timer_core #(.PRESCALE(PRESCALE)) u_core (
        .clk         (clk),
        .res_n       (res_n),
        .en          (ctrl.en),
        .auto_reload (ctrl.auto_reload),
        .load        (load),
        .load_val    ({bus.bus_wdata, reload_lo}),
        .reload      ({reload_hi, reload_lo}),
        .count       (count),
        .uf_pulse    (uf_pulse),
        .en_clear    (en_clear)
    );

    always_comb begin
        mux_data = RST_BYTE;
        case (mux_off)
            REG_CTRL:      mux_data = {5'h00, ctrl};
            REG_STATUS:    mux_data = {6'h00, ctrl.en, uf};
            REG_RELOAD_LO: mux_data = reload_lo;
            REG_RELOAD_HI: mux_data = reload_hi;
            REG_COUNT_LO:  mux_data = count[7:0];
            REG_COUNT_HI:  mux_data = shadow;
            REG_SCRATCH0:  mux_data = scratch0;
            REG_SCRATCH1:  mux_data = scratch1;
            default:       mux_data = RST_BYTE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!res_n) begin
            ctrl      <= '0;
            uf        <= 1'b0;
            reload_lo <= RST_BYTE;
            reload_hi <= RST_BYTE;
            scratch0  <= RST_BYTE;
            scratch1  <= RST_BYTE;
            shadow    <= RST_BYTE;
            rdata_q   <= RST_BYTE;
            irq_q     <= 1'b1;
        end else begin
            irq_q <= !(uf && ctrl.irq_en);
            // a CTRL write overrides the one-shot auto-disable
            if (wr && off == REG_CTRL)
                ctrl <= ctrl_t'(bus.bus_wdata[2:0]);
            else if (en_clear)
                ctrl.en <= 1'b0;
            uf <= uf_pulse || (uf && !(wr && off == REG_STATUS && bus.bus_wdata[STATUS_UF]));
            if (wr && off == REG_RELOAD_LO) reload_lo <= bus.bus_wdata;
            if (wr && off == REG_RELOAD_HI) reload_hi <= bus.bus_wdata;
            if (wr && off == REG_SCRATCH0)  scratch0  <= bus.bus_wdata;
            if (wr && off == REG_SCRATCH1)  scratch1  <= bus.bus_wdata;
            if (capture) begin
                rdata_q <= mux_data;
                if (mux_off == REG_COUNT_LO) shadow <= count[15:8];
            end
        end
    end

`ifdef M6502_TIMER_WAIT_EN
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    rd_state_e  state, state_n;
    logic [3:0] wcnt, wcnt_n, rd_off;
    logic       rdy_q, rdy_n;

    assign mux_off = rd_off;
    assign bus.rdy = rdy_q;

    always_ff @(posedge clk) begin
        if (!res_n) begin
            state  <= S_IDLE;
            wcnt   <= 4'h0;
            rdy_q  <= 1'b1;
            rd_off <= 4'h0;
        end else begin
            state <= state_n;
            wcnt  <= wcnt_n;
            rdy_q <= rdy_n;
            if (rd) rd_off <= off;
        end
    end

    always_comb begin
        state_n = state;
        wcnt_n  = wcnt;
        rdy_n   = rdy_q;
        capture = 1'b0;
        case (state)
            S_IDLE: begin
                if (rd) begin
                    state_n = S_WAIT;
                    wcnt_n  = WAIT_LOAD;
                    rdy_n   = 1'b0;
                end
            end
            S_WAIT: begin
                if (wcnt == 4'h0) begin
                    state_n = S_IDLE;
                    rdy_n   = 1'b1;
                    capture = 1'b1;
                end else begin
                    wcnt_n = wcnt - 4'h1;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end
`else
    assign mux_off = off;
    assign capture = rd;
    assign bus.rdy = 1'b1;
`endif

endmodule
